fetch_unit: RTL and testbench
=============================

# fetch_unit

Fetch stage that produces the fetch-side inputs of the IF/ID pipeline register: `instr_f`, `pc_f` and `pc_plus_4_f`. It owns the PC and talks to instruction memory over a single-outstanding request/response interface. It honours decode-side stall and branch/jump redirects, and discards in-flight responses that a redirect has made stale. When no valid instruction is held, it presents a NOP (0x00000013) so the IF/ID register latches a bubble.

## Interface
- `DW`, 32, data/address width
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `clk_i` input 1 — clock
- `rst_ni` input 1 — reset; asynchronous, active-low
- `stall_i` input 1 — decode stage stalled; the held instruction must not be consumed
- `redirect_i` input 1 — branch/jump taken; wins over `stall_i`
- `redirect_pc_i` input DW — redirect target; bits [1:0] are forced to 0 internally
- `imem_req_o` output 1 — one-cycle request pulse; always accepted by memory
- `imem_addr_o` output DW — request address; equals the internal PC
- `imem_rvalid_i` input 1 — response valid; exactly one response per request, in order, at least 1 cycle after the request
- `imem_rdata_i` input DW — response instruction
- `instr_f` output DW — captured instruction when valid, else 0x00000013
- `pc_f` output DW — PC of `instr_f` (the internal PC)
- `pc_plus_4_f` output DW — `pc_f` + 4, modulo 2^DW
- `fetch_valid_o` output 1 — `instr_f` holds a real instruction
- `fetch_count_o` output 32 — count of instructions consumed by decode

## Operation
- State: `pc_q` (DW), `instr_q` (DW), 2-bit FSM {ISSUE, WAIT, VALID, DROP}, `cnt_q` (32).
- Reset (async, `rst_ni`=0) sets: FSM=ISSUE, `pc_q`=RESET_PC, `instr_q`=0x00000013, `cnt_q`=0.
- Outputs while in reset: `imem_req_o`=0, `fetch_valid_o`=0, `instr_f`=0x00000013, `pc_f`=RESET_PC, `pc_plus_4_f`=RESET_PC+4, `fetch_count_o`=0.
- `imem_req_o` is gated by the deasserted reset.
- ISSUE:
  - `imem_req_o`=1 and `imem_addr_o`=`pc_q`.
  - If `redirect_i`: `pc_q`←target, next state DROP (the request already issued is stale).
  - Otherwise next state WAIT.
- WAIT:
  - `imem_rvalid_i` and no redirect: `instr_q`←`imem_rdata_i`, next state VALID.
  - Redirect without rvalid: `pc_q`←target, next state DROP.
  - Redirect together with rvalid: data discarded, `pc_q`←target, next state ISSUE.
  - Neither: stay in WAIT.
- DROP:
  - On `imem_rvalid_i`: data discarded, next state ISSUE.
  - Redirect in DROP: `pc_q`←new target, stay in DROP. Exactly one response is still owed.
- VALID:
  - `fetch_valid_o`=1 and `instr_f`=`instr_q`.
  - Redirect: `pc_q`←target, instruction discarded (not counted), next state ISSUE.
  - Else if `!stall_i`: instruction consumed, `pc_q`←`pc_q`+4, `cnt_q`←`cnt_q`+1, next state ISSUE.
  - Else: hold every output unchanged.
- In every state other than VALID: `fetch_valid_o`=0 and `instr_f`=0x00000013.
- Arithmetic:
  - PC increment wraps modulo 2^DW, so 0xFFFFFFFC+4 = 0x00000000.
  - `cnt_q` wraps at 2^32.
- `imem_rvalid_i` arriving in ISSUE or VALID is a protocol violation. It is ignored; verification asserts it never occurs.

## Timing
- All state updates on `posedge clk_i`. All outputs are combinational from registered state only; there is no input-to-output path.
- Memory latency L (≥1 cycle from request to rvalid) gives:
  - ISSUE at cycle t, rvalid at t+L, VALID at t+L+1.
  - With L=1 and no stall, one instruction every 3 cycles.
- Redirect from VALID at cycle t: ISSUE at t+1, and the first target instruction is valid at t+2+L.
- Redirect in WAIT before rvalid: DROP until the stale response arrives, then ISSUE on the next cycle.
- Reset assertion mid-WAIT or mid-DROP:
  - Outputs go to their reset values immediately.
  - The memory side is reset together with this block, so no stale response survives reset.

## Test plan
- Reset: hold `rst_ni`=0 for 3 cycles, then release with RESET_PC=0x100 -> during reset `imem_req_o`=0, `instr_f`=0x00000013, `pc_f`=0x100, `pc_plus_4_f`=0x104; first cycle after release `imem_req_o`=1 with `imem_addr_o`=0x100.
- Sequential fetch, L=1, no stall: memory returns 0xA0+n at address 4n -> requests go to 0x0, 0x4, 0x8 every 3 cycles; `fetch_valid_o` is high for 1 cycle each with matching `instr_f`/`pc_f`; `fetch_count_o` reaches 3.
- Stall: `stall_i`=1 for 4 cycles while VALID with `instr_f`=0x00500093 -> all outputs stable, no `imem_req_o`; after release `pc_q` advances by 4 and the count increments by 1.
- Redirect during WAIT, L=3: `redirect_i` with target 0x203 one cycle after the request -> stale rvalid data never appears on `instr_f`; next request goes to 0x200; count unchanged.
- Redirect coincident with rvalid in WAIT, plus redirect in VALID together with `stall_i`=1 -> data discarded, redirect wins over stall, the next request uses the target, `fetch_valid_o` drops the cycle after.
- Wrap and async reset: set PC to 0xFFFFFFFC and consume -> next request goes to 0x00000000 with `pc_plus_4_f`=0x4; assert `rst_ni` asynchronously mid-WAIT -> outputs reset before the next clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: fetch stage feeding the IF/ID register (instr_f, pc_f, pc_plus_4_f).
// Owns the PC and keeps one request outstanding to instruction memory.
// It honours decode stall and branch/jump redirects, and drops responses
// that a redirect has made stale. A NOP bubble is presented when nothing valid is held.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   stall_i                       decode stalled; the held instruction is not consumed
//   redirect_i, redirect_pc_i     branch/jump taken and its target (wins over stall)
//   imem_req_o, imem_addr_o       one-cycle request pulse and address (always accepted)
//   imem_rvalid_i, imem_rdata_i   in-order response, one per request
//   instr_f, pc_f, pc_plus_4_f    fetch-side IF/ID inputs
//   fetch_valid_o                 instr_f holds a real instruction
//   fetch_count_o                 number of instructions consumed by decode
module fetch_unit #(
    parameter int unsigned     DW       = 32,
    parameter logic [DW-1:0]   RESET_PC = '0
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [DW-1:0] redirect_pc_i,
    output logic          imem_req_o,
    output logic [DW-1:0] imem_addr_o,
    input  logic          imem_rvalid_i,
    input  logic [DW-1:0] imem_rdata_i,
    output logic [DW-1:0] instr_f,
    output logic [DW-1:0] pc_f,
    output logic [DW-1:0] pc_plus_4_f,
    output logic          fetch_valid_o,
    output logic [31:0]   fetch_count_o
);

    localparam int unsigned   CW      = 32;
    localparam logic [DW-1:0] NOP     = DW'(32'h0000_0013);
    localparam logic [DW-1:0] PC_STEP = DW'(4);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_DROP  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] instr_q, instr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] target;

    // Redirect targets are word aligned; the low two bits are cleared.
    assign target = redirect_pc_i & ~DW'(3);

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_ISSUE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state. DROP owes exactly one response; its arrival ends DROP even if
    // a further redirect lands in the same cycle, since that redirect issued nothing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ISSUE: state_d = redirect_i ? S_DROP : S_WAIT;
            S_WAIT: begin
                if (redirect_i) begin
                    state_d = imem_rvalid_i ? S_ISSUE : S_DROP;
                end else if (imem_rvalid_i) begin
                    state_d = S_VALID;
                end
            end
            S_DROP: begin
                if (imem_rvalid_i) begin
                    state_d = S_ISSUE;
                end
            end
            S_VALID: begin
                if (redirect_i || !stall_i) begin
                    state_d = S_ISSUE;
                end
            end
            default: state_d = S_ISSUE;
        endcase
    end

    // PC, instruction and consume-count updates. A redirect retargets the PC in any state.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        if (redirect_i) begin
            pc_d = target;
        end else if (state_q == S_VALID && !stall_i) begin
            pc_d  = pc_q + PC_STEP;
            cnt_d = cnt_q + CW'(1);
        end
        if (state_q == S_WAIT && imem_rvalid_i && !redirect_i) begin
            instr_d = imem_rdata_i;
        end
    end

    // Outputs depend on registered state only; the request is masked while reset is held.
    always_comb begin
        imem_req_o    = 1'b0;
        fetch_valid_o = 1'b0;
        instr_f       = NOP;
        case (state_q)
            S_ISSUE: imem_req_o = rst_ni;
            S_VALID: begin
                fetch_valid_o = 1'b1;
                instr_f       = instr_q;
            end
            default: ;
        endcase
    end

    assign imem_addr_o   = pc_q;
    assign pc_f          = pc_q;
    assign pc_plus_4_f   = pc_q + PC_STEP;
    assign fetch_count_o = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a latency-programmable memory model
// and a scoreboard of expected {pc, instr} fetches.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    logic        clk_i;
    logic        rst_ni;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus_4_f;
    logic        fetch_valid_o;
    logic [31:0] fetch_count_o;

    fetch_unit #(
        .DW       (32),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_f       (instr_f),
        .pc_f          (pc_f),
        .pc_plus_4_f   (pc_plus_4_f),
        .fetch_valid_o (fetch_valid_o),
        .fetch_count_o (fetch_count_o)
    );

    localparam logic [31:0] NOP = 32'h0000_0013;

    int          n_tests = 0;
    int          n_fail  = 0;
    fetch_t      sb[$];
    logic [31:0] exp_cnt = '0;

    // memory model state
    int          lat      = 1;
    logic        mem_pend = 1'b0;
    int          mem_cd   = 0;
    logic [31:0] mem_addr = '0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0000_000C) return 32'h0050_0093;
        return 32'h0000_00A0 + {2'b00, addr[31:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory: a request seen in cycle t is answered during cycle t+lat.
    task automatic mem_update();
        imem_rvalid_i = 1'b0;
        if (mem_pend) begin
            mem_cd--;
            if (mem_cd == 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem_word(mem_addr);
                mem_pend      = 1'b0;
            end
        end
        if (imem_req_o) begin
            mem_pend = 1'b1;
            mem_cd   = lat;
            mem_addr = imem_addr_o;
        end
    endtask

    // One clock: check the ending cycle against the scoreboard, advance, update memory.
    task automatic step();
        fetch_t exp;
        n_tests++;
        assert ((imem_rvalid_i && (imem_req_o || fetch_valid_o)) === 1'b0) else begin
            n_fail++;
            $error("FAIL proto_rvalid: observed 1 expected 0");
        end
        if (fetch_valid_o) begin
            n_tests++;
            assert ((sb.size() != 0) === 1'b1) else begin
                n_fail++;
                $error("FAIL unexpected_valid: observed pc %h instr %h expected none", pc_f, instr_f);
            end
            if (sb.size() != 0) begin
                exp = sb[0];
                chk("sb_instr_f", instr_f, exp.instr);
                chk("sb_pc_f", pc_f, exp.pc);
                chk("sb_pc_plus_4_f", pc_plus_4_f, exp.pc + 32'd4);
                if (redirect_i || !stall_i) begin
                    void'(sb.pop_front());
                    if (!redirect_i) exp_cnt = exp_cnt + 32'd1;
                end
            end
        end
        @(posedge clk_i);
        #1;
        chk("fetch_count_o", fetch_count_o, exp_cnt);
        mem_update();
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (imem_req_o) break;
            step();
        end
        chk({tag, "_req"}, 32'(imem_req_o), 32'd1);
        chk({tag, "_addr"}, imem_addr_o, addr);
    endtask

    initial begin
        rst_ni        = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;

        // Reset held for 3 cycles
        repeat (3) step();
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(fetch_valid_o), 32'd0);
        chk("rst_instr_f", instr_f, NOP);
        chk("rst_pc_f", pc_f, 32'h100);
        chk("rst_pc_plus_4_f", pc_plus_4_f, 32'h104);
        chk("rst_count", fetch_count_o, 32'd0);
        rst_ni = 1'b1;
        #1;
        mem_update();
        chk("rel_req", 32'(imem_req_o), 32'd1);
        chk("rel_addr", imem_addr_o, 32'h100);

        // Redirect in ISSUE to 0; the request to 0x100 becomes stale
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0;
        step();
        redirect_i = 1'b0;
        chk("drop_pc_f", pc_f, 32'h0);
        chk("drop_valid", 32'(fetch_valid_o), 32'd0);
        step();

        // Sequential fetch, L=1: one instruction every 3 cycles
        for (int n = 0; n < 3; n++) begin
            sb.push_back('{pc: 32'(4 * n), instr: 32'h0000_00A0 + 32'(n)});
        end
        for (int n = 0; n < 3; n++) begin
            chk("seq_req", 32'(imem_req_o), 32'd1);
            chk("seq_addr", imem_addr_o, 32'(4 * n));
            step();
            chk("seq_wait_instr_f", instr_f, NOP);
            step();
            chk("seq_valid", 32'(fetch_valid_o), 32'd1);
            step();
        end
        chk("seq_count", fetch_count_o, 32'd3);

        // Stall while VALID with 0x00500093 at 0xC
        sb.push_back('{pc: 32'h0000_000C, instr: 32'h0050_0093});
        step();
        step();
        chk("stall_valid0", 32'(fetch_valid_o), 32'd1);
        stall_i = 1'b1;
        repeat (4) begin
            step();
            chk("stall_instr_f", instr_f, 32'h0050_0093);
            chk("stall_pc_f", pc_f, 32'h0000_000C);
            chk("stall_pc_plus_4_f", pc_plus_4_f, 32'h0000_0010);
            chk("stall_req", 32'(imem_req_o), 32'd0);
            chk("stall_valid", 32'(fetch_valid_o), 32'd1);
        end
        stall_i = 1'b0;
        lat     = 3;
        step();
        chk("unstall_req", 32'(imem_req_o), 32'd1);
        chk("unstall_addr", imem_addr_o, 32'h10);
        chk("unstall_count", fetch_count_o, 32'd4);

        // Redirect in WAIT with L=3, target 0x203
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0203;
        step();
        redirect_i = 1'b0;
        lat        = 2;
        chk("rdw_pc_f", pc_f, 32'h200);
        chk("rdw_instr_f", instr_f, NOP);
        chk("rdw_req", 32'(imem_req_o), 32'd0);
        wait_req("rdw_next", 32'h200, 10);
        chk("rdw_count", fetch_count_o, 32'd4);

        // Redirect coincident with rvalid in WAIT
        step();
        step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0300;
        lat           = 1;
        step();
        redirect_i = 1'b0;
        chk("rdv_req", 32'(imem_req_o), 32'd1);
        chk("rdv_addr", imem_addr_o, 32'h300);
        chk("rdv_valid", 32'(fetch_valid_o), 32'd0);

        // Redirect in VALID together with stall: redirect wins
        sb.push_back('{pc: 32'h0000_0300, instr: mem_word(32'h300)});
        step();
        step();
        chk("rvs_valid0", 32'(fetch_valid_o), 32'd1);
        stall_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0400;
        step();
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        chk("rvs_valid", 32'(fetch_valid_o), 32'd0);
        chk("rvs_req", 32'(imem_req_o), 32'd1);
        chk("rvs_addr", imem_addr_o, 32'h400);
        chk("rvs_count", fetch_count_o, 32'd4);

        // PC wrap at 0xFFFFFFFC
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        wait_req("wrap_top", 32'hFFFF_FFFC, 10);
        chk("wrap_top_pc4", pc_plus_4_f, 32'h0);
        sb.push_back('{pc: 32'hFFFF_FFFC, instr: mem_word(32'hFFFF_FFFC)});
        step();
        step();
        lat = 3;
        step();
        chk("wrap_addr", imem_addr_o, 32'h0);
        chk("wrap_pc_f", pc_f, 32'h0);
        chk("wrap_pc4", pc_plus_4_f, 32'h4);
        chk("wrap_count", fetch_count_o, 32'd5);

        // Async reset mid-WAIT; outputs must reset before the next clock edge
        step();
        #3;
        rst_ni = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req_o), 32'd0);
        chk("arst_valid", 32'(fetch_valid_o), 32'd0);
        chk("arst_instr_f", instr_f, NOP);
        chk("arst_pc_f", pc_f, 32'h100);
        chk("arst_pc4", pc_plus_4_f, 32'h104);
        chk("arst_count", fetch_count_o, 32'd0);
        mem_pend      = 1'b0;
        imem_rvalid_i = 1'b0;
        exp_cnt       = '0;
        step();
        step();
        rst_ni = 1'b1;
        #1;
        mem_update();
        chk("arel_req", 32'(imem_req_o), 32'd1);
        chk("arel_addr", imem_addr_o, 32'h100);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
